// File: rtl/namco_latch_bank_pkg.sv
// Shared bit assignments, default window bases and the window decode helper
// for the Namco 6809 control-latch bank.
package namco_latch_pkg;

    localparam int LB_SIRQ  = 0;
    localparam int LB_MIRQ  = 1;
    localparam int LB_SND   = 3;
    localparam int LB_IORST = 4;
    localparam int LB_SRST  = 5;

    localparam logic [15:0] LB_M_BASE_DEF   = 16'h5000;
    localparam logic [15:0] LB_S_BASE_DEF   = 16'h2000;
    localparam logic [7:0]  LB_S_WMASK_DEF  = 8'h29;
    localparam logic [4:0]  LB_SCR_BASE_DEF = 5'b00111;

    // True when adrs lies in the window starting at base; lsb is the first
    // address bit above the latch-select and data fields.
    function automatic logic lb_win_hit(input logic [15:0] adrs,
                                        input logic [15:0] base,
                                        input int          lsb);
        return (adrs >> lsb) == (base >> lsb);
    endfunction

endpackage

// File: rtl/namco_latch_bank_irq_gen.sv
// One CPU interrupt source: either a VBLANK-rise pending flag cleared by
// dropping the enable, or a plain enable-and-VBLANK level.
module namco_irq_gen #(
    parameter bit IRQ_EDGE = 1'b1
) (
    input  logic MCLK,
    input  logic RESET_N,
    input  logic VBLANK,
    input  logic EN_OLD,
    input  logic EN_NEW,
    output logic IRQ
);

    generate
        if (IRQ_EDGE) begin : g_edge
            logic vblank_d_reg;
            logic pend_reg;
            logic pend_next;
            logic rise;

            assign rise = VBLANK & ~vblank_d_reg;
            // A rise only arms when the enable was already set; writing the
            // enable low always clears, even against a simultaneous rise.
            assign pend_next = EN_NEW ? (pend_reg | (rise & EN_OLD)) : 1'b0;

            always_ff @(posedge MCLK) begin
                if (!RESET_N) begin
                    vblank_d_reg <= 1'b0;
                    pend_reg     <= 1'b0;
                end else begin
                    vblank_d_reg <= VBLANK;
                    pend_reg     <= pend_next;
                end
            end

            assign IRQ = pend_reg;
        end else begin : g_level
            logic unused_level;
            assign unused_level = EN_NEW | MCLK | RESET_N;
            assign IRQ = EN_OLD & VBLANK;
        end
    endgenerate

endmodule

// File: rtl/namco_latch_bank.sv
// Control-latch bank shared by main and sub CPU: addressed set/clear latch,
// BG scroll register, IRQ generation and a stretched sub-CPU reset.
module namco_latch_bank
    import namco_latch_pkg::*;
#(
    parameter int                 NLATCH   = 8,
    parameter logic [15:0]        M_BASE   = LB_M_BASE_DEF,
    parameter logic [15:0]        S_BASE   = LB_S_BASE_DEF,
    parameter logic [NLATCH-1:0]  S_WMASK  = LB_S_WMASK_DEF,
    parameter logic [4:0]         SCR_BASE = LB_SCR_BASE_DEF,
    parameter int                 SCR_W    = 8,
    parameter bit                 IRQ_EDGE = 1'b1,
    parameter int                 RST_HOLD = 16
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic [15:0]       M_ADRS,
    input  logic              M_VMA,
    input  logic              M_WE,
    input  logic [15:0]       S_ADRS,
    input  logic              S_VMA,
    input  logic              S_WE,
    input  logic              VBLANK,
    output logic [NLATCH-1:0] LATCH,
    output logic [SCR_W-1:0]  SCROLL,
    output logic              M_IRQ,
    output logic              S_IRQ,
    output logic              SND_EN,
    output logic              IO_RESET,
    output logic              SCPU_RESET
);

    localparam int IW = $clog2(NLATCH);
    localparam int HW = $clog2(RST_HOLD + 1);

    logic [NLATCH-1:0] latch_reg;
    logic [NLATCH-1:0] latch_next;
    logic [SCR_W-1:0]  scroll_reg;
    logic [HW-1:0]     hold_reg;
    logic [HW-1:0]     hold_next;
    logic              m_hit;
    logic              s_hit;
    logic              scr_hit;
    logic [IW-1:0]     m_idx;
    logic [IW-1:0]     s_idx;

    assign m_idx   = M_ADRS[IW:1];
    assign s_idx   = S_ADRS[IW:1];
    assign m_hit   = M_VMA & M_WE & lb_win_hit(M_ADRS, M_BASE, IW + 1);
    assign s_hit   = S_VMA & S_WE & lb_win_hit(S_ADRS, S_BASE, IW + 1) & S_WMASK[s_idx];
    assign scr_hit = M_VMA & M_WE & (M_ADRS[15:11] == SCR_BASE);

    // Sub CPU takes priority when both address the same bit.
    genvar gi;
    generate
        for (gi = 0; gi < NLATCH; gi++) begin : g_bit
            assign latch_next[gi] = (s_hit && s_idx == IW'(gi)) ? S_ADRS[0] :
                                    (m_hit && m_idx == IW'(gi)) ? M_ADRS[0] :
                                                                   latch_reg[gi];
        end
    endgenerate

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            latch_reg  <= '0;
            scroll_reg <= '0;
        end else begin
            latch_reg <= latch_next;
            if (scr_hit) begin
                scroll_reg <= M_ADRS[SCR_W+2:3];
            end
        end
    end

    // Counts down only while the release bit is held; any re-assert reloads.
    always_comb begin
        hold_next = hold_reg;
        if (!latch_reg[LB_SRST]) begin
            hold_next = HW'(RST_HOLD);
        end else if (hold_reg != '0) begin
            hold_next = hold_reg - 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            hold_reg <= HW'(RST_HOLD);
        end else begin
            hold_reg <= hold_next;
        end
    end

    namco_irq_gen #(.IRQ_EDGE(IRQ_EDGE)) u_mirq (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .VBLANK  (VBLANK),
        .EN_OLD  (latch_reg[LB_MIRQ]),
        .EN_NEW  (latch_next[LB_MIRQ]),
        .IRQ     (M_IRQ)
    );

    namco_irq_gen #(.IRQ_EDGE(IRQ_EDGE)) u_sirq (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .VBLANK  (VBLANK),
        .EN_OLD  (latch_reg[LB_SIRQ]),
        .EN_NEW  (latch_next[LB_SIRQ]),
        .IRQ     (S_IRQ)
    );

    assign LATCH      = latch_reg;
    assign SCROLL     = scroll_reg;
    assign SND_EN     = latch_reg[LB_SND];
    assign IO_RESET   = ~latch_reg[LB_IORST];
    assign SCPU_RESET = ~latch_reg[LB_SRST] | (hold_reg != '0);

endmodule

// File: tb/tb_namco_latch_bank.sv
// Self-checking bench: directed scenarios plus random bus traffic against a
// behavioural model of the latch bank (edge-mode and level-mode instances).
module tb_namco_latch_bank;

    localparam int RST_HOLD = 16;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic [15:0] M_ADRS, S_ADRS;
    logic        M_VMA, M_WE, S_VMA, S_WE, VBLANK;

    logic [7:0]  LATCH, SCROLL, l_LATCH, l_SCROLL;
    logic        M_IRQ, S_IRQ, SND_EN, IO_RESET, SCPU_RESET;
    logic        l_M_IRQ, l_S_IRQ, l_SND_EN, l_IO_RESET, l_SCPU_RESET;

    always #5 MCLK = ~MCLK;

    namco_latch_bank dut (
        .MCLK(MCLK), .RESET_N(RESET_N),
        .M_ADRS(M_ADRS), .M_VMA(M_VMA), .M_WE(M_WE),
        .S_ADRS(S_ADRS), .S_VMA(S_VMA), .S_WE(S_WE),
        .VBLANK(VBLANK),
        .LATCH(LATCH), .SCROLL(SCROLL), .M_IRQ(M_IRQ), .S_IRQ(S_IRQ),
        .SND_EN(SND_EN), .IO_RESET(IO_RESET), .SCPU_RESET(SCPU_RESET)
    );

    namco_latch_bank #(.IRQ_EDGE(1'b0)) dut_lvl (
        .MCLK(MCLK), .RESET_N(RESET_N),
        .M_ADRS(M_ADRS), .M_VMA(M_VMA), .M_WE(M_WE),
        .S_ADRS(S_ADRS), .S_VMA(S_VMA), .S_WE(S_WE),
        .VBLANK(VBLANK),
        .LATCH(l_LATCH), .SCROLL(l_SCROLL), .M_IRQ(l_M_IRQ), .S_IRQ(l_S_IRQ),
        .SND_EN(l_SND_EN), .IO_RESET(l_IO_RESET), .SCPU_RESET(l_SCPU_RESET)
    );

    // Reference state
    logic [7:0] latch_m;
    logic [7:0] scroll_m;
    logic [1:0] pend_m;
    logic       vbd_m;
    int         rel_m;              // edges seen since the sub reset was last released
    logic [7:0] sub_ok = 8'h29;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a, input logic [15:0] base);
        return (a >= base) && (a < base + 16'd16);
    endfunction

    task automatic model_edge();
        logic [7:0] nl;
        logic       rise;
        int         idx;
        if (!RESET_N) begin
            latch_m  = '0;
            scroll_m = '0;
            pend_m   = '0;
            vbd_m    = 1'b0;
            rel_m    = 0;
        end else begin
            nl = latch_m;
            if (M_VMA && M_WE && in_win(M_ADRS, 16'h5000)) begin
                idx = int'(M_ADRS - 16'h5000) / 2;
                nl[idx] = M_ADRS[0];
            end
            if (S_VMA && S_WE && in_win(S_ADRS, 16'h2000)) begin
                idx = int'(S_ADRS - 16'h2000) / 2;
                if (sub_ok[idx]) nl[idx] = S_ADRS[0];
            end
            rise = VBLANK && !vbd_m;
            pend_m[1] = nl[1] ? (pend_m[1] | (rise & latch_m[1])) : 1'b0;
            pend_m[0] = nl[0] ? (pend_m[0] | (rise & latch_m[0])) : 1'b0;
            rel_m = latch_m[5] ? ((rel_m < 1000) ? rel_m + 1 : rel_m) : 0;
            if (M_VMA && M_WE && M_ADRS >= 16'h3800 && M_ADRS <= 16'h3FFF)
                scroll_m = 8'((M_ADRS >> 3) % 256);
            latch_m = nl;
            vbd_m   = VBLANK;
        end
    endtask

    task automatic compare_all();
        logic srst_exp;
        srst_exp = !latch_m[5] || (rel_m < RST_HOLD);
        chk("latch",      32'(LATCH),      32'(latch_m));
        chk("scroll",     32'(SCROLL),     32'(scroll_m));
        chk("m_irq",      32'(M_IRQ),      32'(pend_m[1]));
        chk("s_irq",      32'(S_IRQ),      32'(pend_m[0]));
        chk("snd_en",     32'(SND_EN),     32'(latch_m[3]));
        chk("io_reset",   32'(IO_RESET),   32'(!latch_m[4]));
        chk("scpu_reset", 32'(SCPU_RESET), 32'(srst_exp));
        chk("lvl_latch",  32'(l_LATCH),    32'(latch_m));
        chk("lvl_scroll", 32'(l_SCROLL),   32'(scroll_m));
        chk("lvl_m_irq",  32'(l_M_IRQ),    32'(latch_m[1] & VBLANK));
        chk("lvl_s_irq",  32'(l_S_IRQ),    32'(latch_m[0] & VBLANK));
        chk("lvl_snd",    32'(l_SND_EN),   32'(latch_m[3]));
        chk("lvl_iorst",  32'(l_IO_RESET), 32'(!latch_m[4]));
        chk("lvl_srst",   32'(l_SCPU_RESET), 32'(srst_exp));
    endtask

    task automatic step();
        logic [15:0] ma, sa;
        logic        mw, sw, vb, rn;
        ma = M_ADRS; sa = S_ADRS; mw = M_VMA & M_WE; sw = S_VMA & S_WE; vb = VBLANK; rn = RESET_N;
        @(posedge MCLK);
        model_edge();
        #1;
        cyc++;
        compare_all();
        $display("cyc %0d rst_n=%b m=%h/%b s=%h/%b vb=%b -> latch=%h scroll=%h mirq=%b sirq=%b srst=%b",
                 cyc, rn, ma, mw, sa, sw, vb, LATCH, SCROLL, M_IRQ, S_IRQ, SCPU_RESET);
    endtask

    task automatic idle();
        M_VMA = 1'b0; M_WE = 1'b0; S_VMA = 1'b0; S_WE = 1'b0;
    endtask

    task automatic m_wr(input logic [15:0] a);
        M_ADRS = a; M_VMA = 1'b1; M_WE = 1'b1;
        step();
        idle();
    endtask

    task automatic s_wr(input logic [15:0] a);
        S_ADRS = a; S_VMA = 1'b1; S_WE = 1'b1;
        step();
        idle();
    endtask

    function automatic logic [15:0] pick_adrs(input logic [15:0] base);
        case ($urandom_range(0, 4))
            0, 1:    return base + 16'($urandom_range(0, 15));
            2:       return 16'h3800 + 16'($urandom_range(0, 2047));
            3:       return base + 16'h0010 + 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int cnt;
        RESET_N = 1'b0; M_ADRS = '0; S_ADRS = '0; VBLANK = 1'b0;
        idle();

        // Reset state
        step(); step();
        chk("rst_latch",  32'(LATCH),      32'h00);
        chk("rst_scroll", 32'(SCROLL),     32'h00);
        chk("rst_srst",   32'(SCPU_RESET), 32'h1);
        chk("rst_iorst",  32'(IO_RESET),   32'h1);
        chk("rst_mirq",   32'(M_IRQ),      32'h0);
        chk("rst_sirq",   32'(S_IRQ),      32'h0);
        RESET_N = 1'b1;

        // Main IRQ on VBLANK rise, held past VBLANK fall, cleared by enable
        m_wr(16'h5003);
        chk("t2_en", 32'(LATCH[1]), 32'h1);
        step();
        VBLANK = 1'b1; step();
        chk("t2_irq_set", 32'(M_IRQ), 32'h1);
        VBLANK = 1'b0; step();
        chk("t2_irq_hold", 32'(M_IRQ), 32'h1);
        m_wr(16'h5002);
        chk("t2_irq_clr", 32'(M_IRQ), 32'h0);

        // Simultaneous writes to one bit, and a masked sub write
        M_ADRS = 16'h5000; M_VMA = 1'b1; M_WE = 1'b1;
        S_ADRS = 16'h2001; S_VMA = 1'b1; S_WE = 1'b1;
        step(); idle();
        chk("t3_sub_wins", 32'(LATCH[0]), 32'h1);
        s_wr(16'h2003);
        chk("t3_masked", 32'(LATCH[1]), 32'h0);

        // Sub reset stretch: short release absorbed, drop RST_HOLD after last release
        m_wr(16'h500B);
        step(); step();
        m_wr(16'h500A);
        chk("t4_held", 32'(SCPU_RESET), 32'h1);
        m_wr(16'h500B);
        chk("t4_held2", 32'(SCPU_RESET), 32'h1);
        cnt = 0;
        while (SCPU_RESET && cnt < 40) begin
            step();
            cnt++;
        end
        chk("t4_hold_len", 32'(cnt), 32'd16);

        // Scroll: main only
        m_wr(16'h3A28);
        chk("t5_scroll", 32'(SCROLL), 32'h45);
        s_wr(16'h3A28);
        chk("t5_sub_noscroll", 32'(SCROLL), 32'h45);

        // Enable cleared in the same cycle as a VBLANK rise
        m_wr(16'h5001);
        step();
        VBLANK = 1'b1; step();
        chk("t6_pend", 32'(S_IRQ), 32'h1);
        chk("t6_lvl_on", 32'(l_S_IRQ), 32'h1);
        VBLANK = 1'b0; step();
        M_ADRS = 16'h5000; M_VMA = 1'b1; M_WE = 1'b1; VBLANK = 1'b1;
        step(); idle();
        chk("t6_clr_wins", 32'(S_IRQ), 32'h0);
        chk("t6_lvl_off", 32'(l_S_IRQ), 32'h0);
        step();
        chk("t6_no_reset", 32'(S_IRQ), 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            RESET_N = ($urandom_range(0, 199) != 0);
            M_ADRS  = pick_adrs(16'h5000);
            S_ADRS  = pick_adrs(16'h2000);
            M_VMA   = ($urandom_range(0, 9) < 7);
            M_WE    = ($urandom_range(0, 9) < 8);
            S_VMA   = ($urandom_range(0, 9) < 6);
            S_WE    = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 5) == 0) VBLANK = ~VBLANK;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
